// File: rtl/fft_bitrev_reader.sv
// Ping-pong frame buffer that turns a bit-reversed FFT output
// stream into natural frequency order, one sample per cycle.
module fft_bitrev_reader #(
    parameter int WL   = 16,
    parameter int LOGN = 4
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iVALID,
    input  logic [WL-1:0] iRE,
    input  logic [WL-1:0] iIM,
    output logic          oVALID,
    output logic [WL-1:0] oRE,
    output logic [WL-1:0] oIM,
    output logic          oSOF,
    output logic          oEOF,
    output logic          oOVF
);

    localparam int N = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST = '1;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t          state_q;
    logic [LOGN-1:0] wptr_q;
    logic [LOGN-1:0] wptr_d;
    logic [LOGN-1:0] rptr_q;
    logic [LOGN-1:0] rptr_d;
    logic            wbank_q;

    // Both banks share one array; the top address bit selects the bank.
    logic [2*WL-1:0] mem [2*N];
    logic [2*WL-1:0] rdata_q;
    logic [LOGN:0]   waddr;
    logic [LOGN:0]   raddr;

    // Read-stage sideband, aligned with rdata_q.
    logic v1_q;
    logic sof1_q;
    logic eof1_q;

    // Completion of a write frame; kept as a named net so it can be
    // overridden to exercise the overflow path.
    logic swap;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    assign wptr_d = wptr_q + 1'b1;
    assign rptr_d = rptr_q + 1'b1;
    assign swap   = iVALID && !iCLR && (wptr_q == LAST);
    assign waddr  = {wbank_q, wptr_q};
    assign raddr  = {~wbank_q, bitrev(rptr_q)};

    // Sample storage: write into the write bank, registered read from
    // the read bank. The banks never alias, so no read/write hazard.
    always_ff @(posedge iCLK) begin
        if (iVALID && !iCLR) begin
            mem[waddr] <= {iRE, iIM};
        end
        rdata_q <= mem[raddr];
    end

    // Write pointer, bank swap, read FSM and registered outputs.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            wbank_q <= 1'b0;
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            oVALID  <= 1'b0;
            oSOF    <= 1'b0;
            oEOF    <= 1'b0;
            oOVF    <= 1'b0;
            oRE     <= '0;
            oIM     <= '0;
        end else if (iCLR) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            oVALID  <= 1'b0;
            oSOF    <= 1'b0;
            oEOF    <= 1'b0;
            oOVF    <= 1'b0;
        end else begin
            v1_q   <= (state_q == READ);
            sof1_q <= (state_q == READ) && (rptr_q == '0);
            eof1_q <= (state_q == READ) && (rptr_q == LAST);

            oVALID <= v1_q;
            oSOF   <= v1_q && sof1_q;
            oEOF   <= v1_q && eof1_q;
            if (v1_q) begin
                {oRE, oIM} <= rdata_q;
            end

            if (iVALID) begin
                wptr_q <= wptr_d;
            end

            if (swap) begin
                wbank_q <= ~wbank_q;
                state_q <= READ;
                rptr_q  <= '0;
                if (state_q == READ && rptr_q != LAST) begin
                    oOVF <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        rptr_q <= '0;
                    end
                    READ: begin
                        if (rptr_q == LAST) begin
                            state_q <= IDLE;
                            rptr_q  <= '0;
                        end else begin
                            rptr_q <= rptr_d;
                        end
                    end
                endcase
            end
        end
    end

endmodule
